// File: rtl/lut_cell_pkg.sv
// Shared types and sizing helpers for the K-input LUT logic cell.
// Optional feature macro used by this slice: LUT_CFG_PARITY_EN.
package lut_cell_pkg;

  localparam int K_DEFAULT = 4;

  function automatic int lut_w(input int k);
    return 1 << k;
  endfunction

  function automatic int cfg_len(input int k);
    return lut_w(k) + 2;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } cfg_state_t;

  // Layout of the configuration word at the default K, MSB first on the chain
  typedef struct packed {
    logic [(1 << K_DEFAULT)-1:0] truth;
    logic                        reg_mode;
    logic                        init;
  } cfg_word_t;

endpackage

// File: rtl/lut_cfg_loader.sv
// Serial configuration loader: FSM, bit counter, shadow shift register and chain output.
// With LUT_CFG_PARITY_EN a trailing even-parity bit is checked before committing.
module lut_cfg_loader
  import lut_cell_pkg::*;
#(
  parameter int K = K_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic                    cfg_valid,
  input  logic                    cfg_in,
  output logic                    cfg_out,
  output logic                    cfg_ready,
  output logic                    cfg_done,
  output logic                    cfg_err,
  output logic                    busy,
  output logic                    commit_pulse,
  output logic [cfg_len(K)-1:0]   shadow_word
);

  localparam int CFG_LEN = cfg_len(K);
`ifdef LUT_CFG_PARITY_EN
  localparam int STREAM_LEN = CFG_LEN + 1;
`else
  localparam int STREAM_LEN = CFG_LEN;
`endif
  localparam int CNT_W = $clog2(STREAM_LEN + 1);

  cfg_state_t         state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [CFG_LEN-1:0] shadow_q;
  logic               last_bit;
  logic               parity_ok;

  assign last_bit = (state_q == SHIFT) && !cfg_start && cfg_valid &&
                    (count_q == CNT_W'(STREAM_LEN - 1));

`ifdef LUT_CFG_PARITY_EN
  logic parity_q;
  logic err_q;

  assign parity_ok = ~(parity_q ^ cfg_in);
  assign cfg_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= last_bit && !parity_ok;
      if (cfg_start && (state_q != COMMIT)) begin
        parity_q <= 1'b0;
      end else if ((state_q == SHIFT) && cfg_valid) begin
        parity_q <= parity_q ^ cfg_in;
      end
    end
  end
`else
  assign parity_ok = 1'b1;
  assign cfg_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = parity_ok ? COMMIT : IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A restart only rewinds the counter; the shadow keeps its bits so the chain stays continuous
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      shadow_q <= '0;
    end else if (cfg_start && (state_q != COMMIT)) begin
      count_q <= '0;
    end else if ((state_q == SHIFT) && cfg_valid) begin
      count_q <= count_q + CNT_W'(1);
      if (count_q < CNT_W'(CFG_LEN)) begin
        shadow_q <= {shadow_q[CFG_LEN-2:0], cfg_in};
      end
    end
  end

  assign cfg_out      = shadow_q[CFG_LEN-1];
  assign shadow_word  = shadow_q;
  assign cfg_ready    = (state_q == SHIFT);
  assign commit_pulse = (state_q == COMMIT);
  assign cfg_done     = commit_pulse;
  assign busy         = (state_q == SHIFT) || (state_q == COMMIT);

endmodule

// File: rtl/lut_logic_cell.sv
// K-input configurable logic cell: serially loaded LUT with optional output register.
// Build option LUT_CFG_PARITY_EN enables parity checking of the configuration stream.
module lut_logic_cell
  import lut_cell_pkg::*;
#(
  parameter int K = K_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_in,
  output logic         cfg_out,
  output logic         cfg_ready,
  output logic         cfg_done,
  output logic         cfg_err,
  output logic         busy,
  input  logic [K-1:0] lut_in,
  input  logic         ce,
  output logic         f
);

  localparam int LUT_W   = lut_w(K);
  localparam int CFG_LEN = cfg_len(K);

  logic               commit_pulse;
  logic [CFG_LEN-1:0] shadow_word;
  logic [LUT_W-1:0]   active_truth;
  logic               active_reg_mode;
  logic               f_reg;
  logic               f_comb;

  lut_cfg_loader #(
    .K (K)
  ) u_loader (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_valid    (cfg_valid),
    .cfg_in       (cfg_in),
    .cfg_out      (cfg_out),
    .cfg_ready    (cfg_ready),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .busy         (busy),
    .commit_pulse (commit_pulse),
    .shadow_word  (shadow_word)
  );

  // The init bit is consumed directly by f_reg at commit, so only truth and mode are kept active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_truth    <= '0;
      active_reg_mode <= 1'b0;
    end else if (commit_pulse) begin
      active_truth    <= shadow_word[CFG_LEN-1:2];
      active_reg_mode <= shadow_word[1];
    end
  end

  assign f_comb = active_truth[lut_in];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_reg <= 1'b0;
    end else if (commit_pulse) begin
      f_reg <= shadow_word[0];
    end else if (ce) begin
      f_reg <= f_comb;
    end
  end

  assign f = active_reg_mode ? f_reg : f_comb;

endmodule

// File: tb/tb_lut_logic_cell.sv
// Randomized self-checking bench for lut_logic_cell (K=4) against a behavioural model.
// Honours LUT_CFG_PARITY_EN when the design is built with it.
module tb_lut_logic_cell;
  import lut_cell_pkg::*;

`ifdef LUT_CFG_PARITY_EN
  localparam int STREAM = 19;
`else
  localparam int STREAM = 18;
`endif

  logic       clk;
  logic       rst_n;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_in;
  logic       cfg_out;
  logic       cfg_ready;
  logic       cfg_done;
  logic       cfg_err;
  logic       busy;
  logic [3:0] lut_in;
  logic       ce;
  logic       f;

  int errors = 0;
  int checks = 0;
  bit checks_on = 0;

  lut_logic_cell #(.K(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_in    (cfg_in),
    .cfg_out   (cfg_out),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .lut_in    (lut_in),
    .ce        (ce),
    .f         (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the cell as seen from its pins, tracked with plain variables
  logic [15:0] m_truth = '0;
  logic        m_reg_mode = 1'b0;
  logic        m_freg = 1'b0;
  logic [17:0] m_shadow = '0;
  logic        m_loading = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  int          m_count = 0;
  logic        m_par = 1'b0;
  logic        was_done;
  logic        fcomb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_truth = '0; m_reg_mode = 0; m_freg = 0; m_shadow = '0;
      m_loading = 0; m_done = 0; m_err = 0; m_count = 0; m_par = 0;
    end else begin
      was_done = m_done;
      fcomb = m_truth[lut_in];
      m_err = 0;
      if (m_done) begin
        m_truth = m_shadow[17:2];
        m_reg_mode = m_shadow[1];
        m_freg = m_shadow[0];
        m_done = 0;
      end else if (ce) begin
        m_freg = fcomb;
      end
      if (!was_done) begin
        if (cfg_start) begin
          m_loading = 1; m_count = 0; m_par = 0;
        end else if (m_loading && cfg_valid) begin
          if (m_count < 18) m_shadow = {m_shadow[16:0], cfg_in};
          m_par = m_par ^ cfg_in;
          m_count++;
          if (m_count == STREAM) begin
            m_loading = 0;
`ifdef LUT_CFG_PARITY_EN
            m_done = (m_par == 1'b0);
            m_err = (m_par != 1'b0);
`else
            m_done = 1;
`endif
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checks_on) begin
      check_output("f", f, m_reg_mode ? m_freg : m_truth[lut_in]);
      check_output("cfg_out", cfg_out, m_shadow[17]);
      check_output("cfg_ready", cfg_ready, m_loading);
      check_output("cfg_done", cfg_done, m_done);
      check_output("cfg_err", cfg_err, m_err);
      check_output("busy", busy, m_loading | m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_io();
    lut_in = 4'($urandom_range(0, 15));
    ce = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start();
    cfg_start = 1; cfg_valid = 0;
    tick();
    cfg_start = 0;
  endtask

  task automatic send_bit(input logic b, input bit gaps, input bit rand_io);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        cfg_valid = 0; cfg_in = 1'($urandom);
        if (rand_io) randomize_io();
        tick();
      end
    end
    cfg_valid = 1; cfg_in = b;
    if (rand_io) randomize_io();
    tick();
    cfg_valid = 0;
  endtask

  // Streams a full word MSB first; returns in the cycle after the last bit
  task automatic apply_stimulus(input logic [17:0] word, input bit bad_par,
                                input bit gaps, input bit rand_io);
    pulse_start();
    for (int i = 17; i >= 0; i--) send_bit(word[i], gaps, rand_io);
`ifdef LUT_CFG_PARITY_EN
    send_bit((^word) ^ bad_par, gaps, rand_io);
`endif
    cfg_valid = 0;
  endtask

  cfg_word_t w;
  logic [17:0] rw;

  initial begin
    rst_n = 0; cfg_start = 0; cfg_valid = 0; cfg_in = 0; lut_in = 0; ce = 0;
    tick(); tick();
    check_output("reset_f", f, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_cfg_out", cfg_out, 1'b0);
    rst_n = 1;
    checks_on = 1;

    for (int i = 0; i < 16; i++) begin
      lut_in = 4'(i); #1;
      check_output("zero_lut_f", f, 1'b0);
      check_output("idle_ready", cfg_ready, 1'b0);
      tick();
    end

    w.truth = 16'h8000; w.reg_mode = 0; w.init = 0;
    apply_stimulus(w, 0, 0, 0);
    check_output("and4_done", cfg_done, 1'b1);
    tick();
    check_output("and4_done_clear", cfg_done, 1'b0);
    for (int i = 0; i < 16; i++) begin
      lut_in = 4'(i); #1;
      check_output("and4_f", f, (i == 15) ? 1'b1 : 1'b0);
      tick();
    end

    lut_in = 0; ce = 0;
    w.truth = 16'h6996; w.reg_mode = 1; w.init = 1;
    apply_stimulus(w, 0, 0, 0);
    tick();
    check_output("xor4_init", f, 1'b1);
    lut_in = 4'h1; ce = 1; tick();
    check_output("xor4_ce1", f, 1'b1);
    lut_in = 4'h3; ce = 0; tick();
    check_output("xor4_hold", f, 1'b1);
    ce = 1; tick();
    check_output("xor4_ce3", f, 1'b0);
    ce = 0;

    // Restart after 7 bits, gapped stream, function inputs toggling throughout
    rw = 18'($urandom);
    pulse_start();
    for (int i = 17; i >= 11; i--) send_bit(rw[i], 1, 1);
    check_output("partial_no_done", cfg_done, 1'b0);
    pulse_start();
    rw = 18'($urandom);
    for (int i = 17; i >= 0; i--) begin
      send_bit(rw[i], 1, 1);
      if (i == 1) check_output("restart_17_no_done", cfg_done, 1'b0);
    end
`ifdef LUT_CFG_PARITY_EN
    send_bit(^rw, 1, 1);
`endif
    check_output("restart_done", cfg_done, 1'b1);
    repeat (4) begin randomize_io(); tick(); end

    // Reset in the middle of a load
    pulse_start();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0, 1);
    rst_n = 0; #1;
    check_output("midreset_f", f, 1'b0);
    check_output("midreset_cfg_out", cfg_out, 1'b0);
    check_output("midreset_ready", cfg_ready, 1'b0);
    check_output("midreset_busy", busy, 1'b0);
    check_output("midreset_done", cfg_done, 1'b0);
    check_output("midreset_err", cfg_err, 1'b0);
    tick();
    rst_n = 1;
    tick();

    repeat (5) begin
      rw = 18'($urandom);
      apply_stimulus(rw, 0, 1, 1);
      check_output("rand_done", cfg_done, 1'b1);
      repeat (8) begin randomize_io(); tick(); end
    end

`ifdef LUT_CFG_PARITY_EN
    ce = 0;
    w.truth = 16'h8000; w.reg_mode = 0; w.init = 0;
    apply_stimulus(w, 0, 0, 0);
    check_output("par_good_done", cfg_done, 1'b1);
    tick();
    w.truth = 16'h0001;
    apply_stimulus(w, 1, 0, 0);
    check_output("par_bad_err", cfg_err, 1'b1);
    check_output("par_bad_no_done", cfg_done, 1'b0);
    tick();
    lut_in = 4'hF; #1;
    check_output("par_bad_retained", f, 1'b1);
    apply_stimulus(w, 0, 0, 0);
    check_output("par_fix_done", cfg_done, 1'b1);
    tick();
    lut_in = 4'h0; #1;
    check_output("par_fix_f", f, 1'b1);
    tick();
`endif

    tick();
    checks_on = 0;
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
